// File: rtl/energy_window_accum.sv
// Per-sample |x|^2 energy of a complex stream plus a sliding sum of the
// last WIN sample energies, for packet detection and AGC.
module energy_window_accum #(
    parameter int DW      = 8,
    parameter int LOG2WIN = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      InputEnable,
    input  logic signed [DW-1:0]      DataInRe,
    input  logic signed [DW-1:0]      DataInIm,
    input  logic                      Clear,
    output logic                      OutputEnable,
    output logic [2*DW-1:0]           DataMagnitude,
    output logic                      WindowEnable,
    output logic [2*DW+LOG2WIN-1:0]   WindowEnergy,
    output logic                      WindowFull
);
    localparam int WIN = 2**LOG2WIN;
    localparam int MW  = 2*DW;
    localparam int SW  = MW + LOG2WIN;
    localparam logic [LOG2WIN:0] FILL_MAX = (LOG2WIN+1)'(WIN);

    logic                   flush;
    logic                   v1_q, v2_q, v3_q, v4_q;
    logic signed [DW-1:0]   re1_q, im1_q;
    logic signed [MW-1:0]   re_ext, im_ext;
    logic signed [MW-1:0]   sqre2_q, sqim2_q;
    logic [MW-1:0]          mag3_q, mag_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic [LOG2WIN-1:0]     ptr_q, ptr_d;
    logic [LOG2WIN:0]       fill_q, fill_d;
    logic                   full_q, full_d;
    logic [MW-1:0]          ring_q [WIN];
    logic [MW-1:0]          oldest;

    assign flush  = Rst | Clear;
    assign re_ext = MW'(re1_q);
    assign im_ext = MW'(im1_q);

    always_comb begin
        mag_d  = sqre2_q + sqim2_q;
        oldest = ring_q[ptr_q];
        ptr_d  = ptr_q + LOG2WIN'(1);
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + (LOG2WIN+1)'(1);
        full_d = (fill_d == FILL_MAX);
        // Oldest entry only leaves the sum once the window has wrapped;
        // before that the ring slot holds stale data from a previous run.
        sum_d  = sum_q + SW'(mag3_q)
               - ((fill_q == FILL_MAX) ? SW'(oldest) : '0);
    end

    always_ff @(posedge Clk) begin
        if (flush) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            re1_q   <= '0;
            im1_q   <= '0;
            sqre2_q <= '0;
            sqim2_q <= '0;
            mag3_q  <= '0;
            sum_q   <= '0;
            ptr_q   <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            v1_q <= InputEnable;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (InputEnable) begin
                re1_q <= DataInRe;
                im1_q <= DataInIm;
            end
            if (v1_q) begin
                sqre2_q <= re_ext * re_ext;
                sqim2_q <= im_ext * im_ext;
            end
            if (v2_q) begin
                mag3_q <= mag_d;
            end
            if (v3_q) begin
                sum_q  <= sum_d;
                ptr_q  <= ptr_d;
                fill_q <= fill_d;
                full_q <= full_d;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (v3_q) begin
            ring_q[ptr_q] <= mag3_q;
        end
    end

    assign OutputEnable  = v3_q;
    assign DataMagnitude = mag3_q;
    assign WindowEnable  = v4_q;
    assign WindowEnergy  = sum_q;
    assign WindowFull    = full_q;

endmodule

// File: tb/tb_energy_window_accum.sv
// Directed and random checks of energy_window_accum at DW=8, WIN=4.
module tb_energy_window_accum;
    localparam int DW  = 8;
    localparam int LW  = 2;
    localparam int WIN = 4;
    localparam int SW  = 2*DW + LW;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b1;
    logic                 InputEnable = 1'b0;
    logic                 Clear = 1'b0;
    logic signed [DW-1:0] DataInRe = '0;
    logic signed [DW-1:0] DataInIm = '0;
    logic                 OutputEnable;
    logic [2*DW-1:0]      DataMagnitude;
    logic                 WindowEnable;
    logic [SW-1:0]        WindowEnergy;
    logic                 WindowFull;

    energy_window_accum #(.DW(DW), .LOG2WIN(LW)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .InputEnable(InputEnable),
        .DataInRe(DataInRe),
        .DataInIm(DataInIm),
        .Clear(Clear),
        .OutputEnable(OutputEnable),
        .DataMagnitude(DataMagnitude),
        .WindowEnable(WindowEnable),
        .WindowEnergy(WindowEnergy),
        .WindowFull(WindowFull)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int oe_cyc[$];
    int we_cyc[$];
    int exp_mag[$];
    int exp_en[$];
    int exp_full[$];
    int model_win[$];

    typedef struct {
        bit rst;
        int re;
        int im;
        int gap;
        int mag;
        int energy;
        int full;
    } vec_t;

    vec_t tbl[17];

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (OutputEnable) begin
            check("oe_pending", longint'(exp_mag.size() > 0), 1);
            if (exp_mag.size() > 0) begin
                check("oe_latency", cyc, oe_cyc.pop_front() + 3);
                check("mag", longint'(DataMagnitude), exp_mag.pop_front());
            end
        end
        if (WindowEnable) begin
            check("we_pending", longint'(exp_en.size() > 0), 1);
            if (exp_en.size() > 0) begin
                check("we_latency", cyc, we_cyc.pop_front() + 4);
                check("energy", longint'(WindowEnergy), exp_en.pop_front());
                check("full", longint'(WindowFull), exp_full.pop_front());
            end
        end
    end

    task automatic drive(bit en, int re, int im, bit clr, bit rst);
        @(negedge Clk);
        InputEnable = en;
        DataInRe    = 8'(re);
        DataInIm    = 8'(im);
        Clear       = clr;
        Rst         = rst;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_exp(int re, int im, int mag, int en, int full);
        drive(1'b1, re, im, 1'b0, 1'b0);
        oe_cyc.push_back(cyc);
        we_cyc.push_back(cyc);
        exp_mag.push_back(mag);
        exp_en.push_back(en);
        exp_full.push_back(full);
    endtask

    task automatic send_model(int re, int im);
        int m;
        int s;
        m = re*re + im*im;
        model_win.push_back(m);
        if (model_win.size() > WIN) void'(model_win.pop_front());
        s = 0;
        foreach (model_win[k]) s += model_win[k];
        send_exp(re, im, m, s, int'(model_win.size() == WIN));
    endtask

    // Rst or Clear for one edge (optionally with a sample that must be
    // dropped), then confirm every output reads zero.
    task automatic flush(bit use_rst, bit en);
        drive(en, 64, 0, !use_rst, use_rst);
        @(negedge Clk);
        check("flush_oe",     longint'(OutputEnable), 0);
        check("flush_mag",    longint'(DataMagnitude), 0);
        check("flush_we",     longint'(WindowEnable), 0);
        check("flush_energy", longint'(WindowEnergy), 0);
        check("flush_full",   longint'(WindowFull), 0);
        oe_cyc.delete();
        we_cyc.delete();
        exp_mag.delete();
        exp_en.delete();
        exp_full.delete();
        model_win.delete();
        Rst         = 1'b0;
        Clear       = 1'b0;
        InputEnable = 1'b0;
    endtask

    initial begin
        // single sample
        tbl[0]  = '{1, 64, 0, 5, 4096, 4096, 0};
        // back-to-back fill and slide
        tbl[1]  = '{1, 64, 64, 0, 8192, 8192, 0};
        tbl[2]  = '{0, 64, 64, 0, 8192, 16384, 0};
        tbl[3]  = '{0, 64, 64, 0, 8192, 24576, 0};
        tbl[4]  = '{0, 64, 64, 0, 8192, 32768, 1};
        tbl[5]  = '{0, 64, 64, 0, 8192, 32768, 1};
        tbl[6]  = '{0, 64, 64, 0, 8192, 32768, 1};
        // most negative inputs, full-range window sum
        tbl[7]  = '{1, -128, -128, 0, 32768, 32768, 0};
        tbl[8]  = '{0, -128, -128, 0, 32768, 65536, 0};
        tbl[9]  = '{0, -128, -128, 0, 32768, 98304, 0};
        tbl[10] = '{0, -128, -128, 0, 32768, 131072, 1};
        // gapped input
        tbl[11] = '{1, 1, 0, 1, 1, 1, 0};
        tbl[12] = '{0, 2, 0, 2, 4, 5, 0};
        tbl[13] = '{0, 3, 0, 3, 9, 14, 0};
        tbl[14] = '{0, 4, 0, 1, 16, 30, 1};
        tbl[15] = '{0, 5, 0, 2, 25, 54, 1};
        tbl[16] = '{0, 6, 0, 3, 36, 86, 1};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) begin
                idle(8);
                flush(1'b1, 1'b0);
            end
            send_exp(tbl[i].re, tbl[i].im, tbl[i].mag,
                     tbl[i].energy, tbl[i].full);
            idle(tbl[i].gap);
        end
        idle(8);

        // Clear with two samples in flight and one on the Clear cycle
        drive(1'b1, 64, 0, 1'b0, 1'b0);
        drive(1'b1, 64, 0, 1'b0, 1'b0);
        flush(1'b0, 1'b1);
        send_exp(64, 0, 4096, 4096, 0);
        idle(1);
        send_exp(64, 0, 4096, 8192, 0);

        // refill, then Rst mid-stream
        send_exp(64, 0, 4096, 12288, 0);
        send_exp(64, 0, 4096, 16384, 1);
        send_exp(64, 0, 4096, 16384, 1);
        drive(1'b1, 64, 64, 1'b0, 1'b0);
        drive(1'b1, 64, 64, 1'b0, 1'b0);
        flush(1'b1, 1'b1);
        send_exp(64, 0, 4096, 4096, 0);
        idle(8);

        // random stream against the reference model
        flush(1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                flush(1'b0, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                send_model(int'($signed(8'($urandom))),
                           int'($signed(8'($urandom))));
            end
        end
        idle(10);
        check("pending_outputs", exp_mag.size() + exp_en.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
